// File: rtl/dsm_sample_scheduler.sv
// dsm_sample_scheduler
// Paces a bursty valid/ready sample stream into the 20-bit signed vin input
// of dsm_top. Samples are buffered in a small FIFO and one is released every
// 2**OSR_LOG2 clocks. The modulator's active-high reset is held until the
// stream is primed. Underrun is flagged (pulse and sticky) and vin holds.
//
// Optional feature: define DSM_INTERP_EN for linear interpolation between
// consecutive samples instead of zero-order hold (needs two samples to prime).
//
// Ports:
//   clock           system clock, shared with dsm_top
//   reset           asynchronous, active-low
//   enable          1 = stream runs, 0 = flush FIFO and park in IDLE
//   s_data/s_valid  producer sample and its valid
//   s_ready         producer ready (push when s_valid && s_ready)
//   clear_err       clears underrun_sticky
//   vin             registered sample to dsm_top.vin
//   dsm_reset       active-high reset to dsm_top.reset
//   sample_strobe   1-clock pulse when a sample is popped from the FIFO
//   underrun        1-clock pulse when a pop is due and the FIFO is empty
//   underrun_sticky set by underrun, cleared by clear_err or reset
//   fifo_level      number of FIFO entries
module dsm_sample_scheduler #(
    parameter int unsigned DW       = 20,
    parameter int unsigned OSR_LOG2 = 6,
    parameter int unsigned DEPTH    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [DW-1:0]       s_data,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic                       clear_err,
    output logic signed [DW-1:0]       vin,
    output logic                       dsm_reset,
    output logic                       sample_strobe,
    output logic                       underrun,
    output logic                       underrun_sticky,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int unsigned AW  = $clog2(DEPTH);
    localparam int unsigned LW  = AW + 1;
    localparam int unsigned ACW = DW + OSR_LOG2 + 1;
    localparam logic [OSR_LOG2-1:0] PHASE_LAST = '1;
`ifdef DSM_INTERP_EN
    localparam logic [LW-1:0] NEED = LW'(2);
`else
    localparam logic [LW-1:0] NEED = LW'(1);
`endif

    typedef enum logic [1:0] {StIdle, StPrime, StRun, StUnder} state_e;

    state_e                state_q, state_d;
    logic [OSR_LOG2-1:0]   phase_q, phase_d;
    logic [DW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_d;
    logic signed [DW-1:0]  vin_q, vin_d;
    logic                  sticky_q, sticky_d;

    logic full, empty, ready_int, push, pop, under, flush;
    logic signed [DW-1:0]  head;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign ready_int = (state_q != StIdle) && !full;
    // While reset is asserted the producer sees ready, as the reset state
    // of s_ready is 1; once released, IDLE keeps it low.
    assign s_ready   = !reset || ready_int;
    assign push      = s_valid && ready_int;
    assign head      = mem[rd_ptr_q];
    assign flush     = !enable || (state_q == StIdle);

    // Sequencing FSM
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pop     = 1'b0;
        under   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StPrime;
            end
            StPrime, StUnder: begin
                if (level_q >= NEED) begin
                    pop     = 1'b1;
                    phase_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                phase_d = phase_q + OSR_LOG2'(1);
                if (phase_q == PHASE_LAST) begin
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        under   = 1'b1;
                        state_d = StUnder;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // Disable overrides everything, including pulses due this cycle.
        if (!enable) begin
            state_d = StIdle;
            phase_d = '0;
            pop     = 1'b0;
            under   = 1'b0;
        end
    end

    assign sample_strobe = pop;
    assign underrun      = under;

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        if (flush) level_d = '0;
    end

    always_comb begin
        sticky_d = sticky_q;
        if (clear_err) sticky_d = 1'b0;
        if (under)     sticky_d = 1'b1;
    end

`ifdef DSM_INTERP_EN
    logic signed [ACW-1:0] acc_q, acc_d, acc_shift;
    logic signed [DW:0]    step_q, step_d;
    logic [AW-1:0]         rd_next;
    logic signed [DW-1:0]  next_sample;
    logic                  next_avail;

    assign rd_next = rd_ptr_q + AW'(1);

    // The sample following the popped one: the second FIFO entry, or the
    // word being pushed this cycle when only one entry is stored.
    always_comb begin
        next_sample = mem[rd_next];
        next_avail  = 1'b0;
        if (level_q >= LW'(2)) begin
            next_avail = 1'b1;
        end else if (push) begin
            next_sample = s_data;
            next_avail  = 1'b1;
        end
    end

    always_comb begin
        acc_d     = acc_q;
        step_d    = step_q;
        vin_d     = vin_q;
        acc_shift = '0;
        if (flush) begin
            acc_d  = '0;
            step_d = '0;
            vin_d  = '0;
        end else if (pop) begin
            acc_d  = $signed({{(ACW-DW){head[DW-1]}}, head}) <<< OSR_LOG2;
            step_d = next_avail ? ($signed({next_sample[DW-1], next_sample})
                                   - $signed({head[DW-1], head})) : '0;
            vin_d  = head;
        end else if (under) begin
            step_d = '0;
        end else if (state_q == StRun) begin
            acc_d     = acc_q + $signed({{(ACW-DW-1){step_q[DW]}}, step_q});
            acc_shift = acc_d >>> OSR_LOG2;
            vin_d     = acc_shift[DW-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q  <= '0;
            step_q <= '0;
        end else begin
            acc_q  <= acc_d;
            step_q <= step_d;
        end
    end
`else
    // Zero-order hold: vin is the popped sample for the whole period.
    always_comb begin
        vin_d = vin_q;
        if (flush)    vin_d = '0;
        else if (pop) vin_d = head;
    end
`endif

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= s_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            phase_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            vin_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            level_q  <= level_d;
            vin_q    <= vin_d;
            sticky_q <= sticky_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign vin             = vin_q;
    assign dsm_reset       = !((state_q == StRun) || (state_q == StUnder));
    assign underrun_sticky = sticky_q;
    assign fifo_level      = level_q;

endmodule

// File: tb/tb_dsm_sample_scheduler.sv
// Self-checking bench for dsm_sample_scheduler: accepted pushes go into a
// scoreboard queue; each sample_strobe pops the expected value, which is
// compared against vin one clock later. Directed checks cover reset,
// priming, pacing, backpressure, underrun, disable and async reset.
module tb_dsm_sample_scheduler;

    localparam int DW = 20;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic          enable    = 1'b0;
    logic          s_valid   = 1'b0;
    logic          clear_err = 1'b0;
    logic [DW-1:0] s_data    = '0;
    logic          s_ready, dsm_reset, sample_strobe, underrun, underrun_sticky;
    logic [DW-1:0] vin;
    logic [2:0]    fifo_level;

    dsm_sample_scheduler #(.DW(DW), .OSR_LOG2(6), .DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .clear_err       (clear_err),
        .vin             (vin),
        .dsm_reset       (dsm_reset),
        .sample_strobe   (sample_strobe),
        .underrun        (underrun),
        .underrun_sticky (underrun_sticky),
        .fifo_level      (fifo_level)
    );

    always #5 clock = ~clock;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic [DW-1:0] exp_q[$];
    bit            pend     = 1'b0;
    int            last_strobe_cyc = 0;
    int            last_gap  = 0;
    int            under_gap = 0;
    int            under_cnt = 0;
    int            strobe_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    always @(posedge clock) cyc++;

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clock) begin
        if (pend) begin
            pend = 1'b0;
            if (exp_q.size() == 0) check_eq("sb_underflow", 32'd1, 32'd0);
            else                   check_eq("sb_vin", vin, exp_q.pop_front());
        end
        if (reset) begin
            if (s_valid && s_ready) exp_q.push_back(s_data);
            if (sample_strobe) begin
                pend = 1'b1;
                strobe_cnt++;
                last_gap        = cyc - last_strobe_cyc;
                last_strobe_cyc = cyc;
            end
            if (underrun) begin
                under_cnt++;
                under_gap = cyc - last_strobe_cyc;
            end
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    logic [DW-1:0] bp [6];
    logic [DW-1:0] exp_v;
    int            k, guard, acc_burst, strobes_before;

    initial begin
        bp[0] = 20'h11111; bp[1] = 20'h80000; bp[2] = 20'h00001;
        bp[3] = 20'hFFFFF; bp[4] = 20'h3C3C3; bp[5] = 20'h55AA5;

        #1 reset = 1'b0;
        #11;
        check_eq("rst_vin", vin, 0);
        check_eq("rst_dsm_reset", dsm_reset, 1);
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_level", fifo_level, 0);
        check_eq("rst_strobe", sample_strobe, 0);
        check_eq("rst_underrun", underrun, 0);
        check_eq("rst_sticky", underrun_sticky, 0);
        @(posedge clock);
        #1 reset = 1'b1;
        #1 check_eq("idle_s_ready", s_ready, 0);

`ifdef DSM_INTERP_EN
        // Ramp 0 -> 64 then hold.
        enable = 1'b1;
        tick(1);
        s_valid = 1'b1;
        s_data = 20'd0;  tick(1);
        s_data = 20'd64; tick(1);
        s_data = 20'd64; tick(1);
        s_valid = 1'b0;
        check_eq("ramp_start", vin, 0);
        for (int i = 1; i < 64; i++) begin
            tick(1);
            check_eq("ramp_up", vin, i);
        end
        tick(1);
        check_eq("ramp_end", vin, 64);
        tick(30);
        check_eq("ramp_hold", vin, 64);
        enable = 1'b0;
        tick(1);
        exp_q.delete();
        // Signed ramp -64 -> 0.
        enable = 1'b1;
        tick(1);
        s_valid = 1'b1;
        s_data = 20'hFFFC0; tick(1);
        s_data = 20'd0;     tick(1);
        s_data = 20'd0;     tick(1);
        s_valid = 1'b0;
        check_eq("neg_start", vin, 20'hFFFC0);
        for (int i = 1; i < 64; i++) begin
            tick(1);
            exp_v = DW'(-64 + i);
            check_eq("neg_ramp", vin, exp_v);
        end
        tick(1);
        check_eq("neg_end", vin, 0);
        enable = 1'b0;
        tick(1);
        exp_q.delete();
`else
        // Prime and zero-order hold pacing.
        enable = 1'b1;
        tick(1);
        check_eq("prime_dsm_reset", dsm_reset, 1);
        s_data = 20'h00100; s_valid = 1'b1;
        tick(1);
        check_eq("prime_level", fifo_level, 1);
        check_eq("prime_hold_reset", dsm_reset, 1);
        s_data = 20'hFFF00;
        tick(1);
        s_valid = 1'b0;
        check_eq("run_dsm_reset", dsm_reset, 0);
        check_eq("run_vin0", vin, 20'h00100);
        check_eq("run_level", fifo_level, 1);
        tick(62);
        check_eq("zoh_hold", vin, 20'h00100);
        check_eq("zoh_no_strobe", sample_strobe, 0);
        tick(1);
        check_eq("strobe_due", sample_strobe, 1);
        check_eq("zoh_hold_last", vin, 20'h00100);
        tick(1);
        check_eq("zoh_vin1", vin, 20'hFFF00);
        check_eq("strobe_gap", last_gap, 64);

        // Backpressure burst of 6 into a 4-deep FIFO.
        k = 0;
        acc_burst = 0;
        for (int c = 0; c < 6; c++) begin
            s_data = bp[k]; s_valid = 1'b1;
            if (s_ready) begin
                acc_burst++;
                k++;
            end
            tick(1);
        end
        check_eq("bp_accepted", acc_burst, 4);
        check_eq("bp_level", fifo_level, 4);
        check_eq("bp_ready", s_ready, 0);
        guard = 0;
        while (k < 6 && guard < 300) begin
            s_data = bp[k]; s_valid = 1'b1;
            if (s_ready) k++;
            tick(1);
            guard++;
        end
        s_valid = 1'b0;
        check_eq("bp_all_in", k, 6);
        guard = 0;
        while ((exp_q.size() != 0 || pend) && guard < 600) begin
            tick(1);
            guard++;
        end
        check_eq("bp_drained", exp_q.size(), 0);
        check_eq("bp_no_underrun", under_cnt, 0);

        // Disable at phase 30 with one sample queued.
        s_data = 20'h0ABCD; s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
        tick(28);
        check_eq("dis_pre_level", fifo_level, 1);
        enable = 1'b0;
        strobes_before = strobe_cnt;
        tick(1);
        check_eq("dis_vin", vin, 0);
        check_eq("dis_dsm_reset", dsm_reset, 1);
        check_eq("dis_level", fifo_level, 0);
        check_eq("dis_ready", s_ready, 0);
        exp_q.delete();
        tick(70);
        check_eq("dis_no_strobe", strobe_cnt, strobes_before);
        check_eq("dis_sticky", underrun_sticky, 0);

        // Underrun after a single sample.
        enable = 1'b1;
        tick(1);
        s_data = 20'h7FFFF; s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
        tick(1);
        check_eq("ur_vin", vin, 20'h7FFFF);
        tick(63);
        check_eq("ur_pulse", underrun, 1);
        check_eq("ur_no_strobe", sample_strobe, 0);
        tick(1);
        check_eq("ur_pulse_end", underrun, 0);
        check_eq("ur_sticky", underrun_sticky, 1);
        check_eq("ur_vin_hold", vin, 20'h7FFFF);
        check_eq("ur_dsm_reset", dsm_reset, 0);
        tick(20);
        check_eq("ur_once", under_cnt, 1);
        check_eq("ur_vin_hold2", vin, 20'h7FFFF);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check_eq("ur_clear", underrun_sticky, 0);
        s_data = 20'h12345; s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
        check_eq("ur_resume_strobe", sample_strobe, 1);
        tick(1);
        check_eq("ur_resume_vin", vin, 20'h12345);
        tick(63);
        check_eq("ur_pulse2", underrun, 1);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check_eq("ur_set_wins", underrun_sticky, 1);
        check_eq("ur_resume_phase", under_gap, 64);
        check_eq("ur_count2", under_cnt, 2);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        check_eq("ur_clear2", underrun_sticky, 0);

        // Asynchronous reset mid-stream with a sample queued.
        s_data = 20'h00AAA; s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
        tick(1);
        check_eq("ar_vin_pre", vin, 20'h00AAA);
        s_data = 20'h00555; s_valid = 1'b1;
        tick(1);
        s_valid = 1'b0;
        tick(1);
        check_eq("ar_level_pre", fifo_level, 1);
        #2 reset = 1'b0;
        #1;
        check_eq("ar_vin", vin, 0);
        check_eq("ar_dsm_reset", dsm_reset, 1);
        check_eq("ar_s_ready", s_ready, 1);
        check_eq("ar_level", fifo_level, 0);
        check_eq("ar_strobe", sample_strobe, 0);
        exp_q.delete();
        pend = 1'b0;
        enable = 1'b0;
        #3 reset = 1'b1;
        tick(2);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
